// File: rtl/writeback_stage_if.sv
// ----------------------------------------------------------------------------
// writeback_stage_if
// Purpose : bundles the ALU result stream, the load-return stream and the
//           registered register-file write port of the writeback stage.
// Signals : alu_valid/alu_ready/alu_wr_addr/alu_ppp/alu_data - ALU results
//           ld_valid/ld_wr_addr/ld_ppp/ld_data              - load returns
//           wen/wr_addr/PPP_sel/data_in                     - RF write port
//           fwd_valid/fwd_addr/fwd_ppp/fwd_data             - forwarding copy
//                                                  (only with WB_FWD_EN)
// Modports: master - pipeline/environment side, slave - writeback stage.
// Macro   : WB_FWD_EN adds the forwarding signals.
// ----------------------------------------------------------------------------
interface writeback_stage_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5
);
   logic                  alu_valid;
   logic                  alu_ready;
   logic [ADDR_WIDTH-1:0] alu_wr_addr;
   logic [2:0]            alu_ppp;
   logic [DATA_WIDTH-1:0] alu_data;

   logic                  ld_valid;
   logic [ADDR_WIDTH-1:0] ld_wr_addr;
   logic [2:0]            ld_ppp;
   logic [DATA_WIDTH-1:0] ld_data;

   logic                  wen;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [2:0]            PPP_sel;
   logic [DATA_WIDTH-1:0] data_in;

`ifdef WB_FWD_EN
   logic                  fwd_valid;
   logic [ADDR_WIDTH-1:0] fwd_addr;
   logic [2:0]            fwd_ppp;
   logic [DATA_WIDTH-1:0] fwd_data;

   modport master (
      output alu_valid, alu_wr_addr, alu_ppp, alu_data,
      output ld_valid, ld_wr_addr, ld_ppp, ld_data,
      input  alu_ready, wen, wr_addr, PPP_sel, data_in,
      input  fwd_valid, fwd_addr, fwd_ppp, fwd_data
   );

   modport slave (
      input  alu_valid, alu_wr_addr, alu_ppp, alu_data,
      input  ld_valid, ld_wr_addr, ld_ppp, ld_data,
      output alu_ready, wen, wr_addr, PPP_sel, data_in,
      output fwd_valid, fwd_addr, fwd_ppp, fwd_data
   );
`else
   modport master (
      output alu_valid, alu_wr_addr, alu_ppp, alu_data,
      output ld_valid, ld_wr_addr, ld_ppp, ld_data,
      input  alu_ready, wen, wr_addr, PPP_sel, data_in
   );

   modport slave (
      input  alu_valid, alu_wr_addr, alu_ppp, alu_data,
      input  ld_valid, ld_wr_addr, ld_ppp, ld_data,
      output alu_ready, wen, wr_addr, PPP_sel, data_in
   );
`endif
endinterface

// File: rtl/writeback_stage.sv
// ----------------------------------------------------------------------------
// writeback_stage
// Purpose : arbitrates load returns and in-order ALU results onto a single
//           registered register-file write port. Loads have no backpressure
//           and always win; ALU results that lose arbitration are parked in a
//           small circular FIFO and drained in acceptance order.
// Ports   : clk   - clock, all state on rising edge
//           reset - asynchronous, active-low reset
//           bus   - writeback_stage_if.slave (ALU in, load in, RF write out)
// Params  : DATA_WIDTH, ADDR_WIDTH, FIFO_DEPTH (power of two, >= 2)
// Macro   : WB_FWD_EN - drive the fwd_* forwarding copy of the RF write port.
// ----------------------------------------------------------------------------
module writeback_stage #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input logic              clk,
   input logic              reset,
   writeback_stage_if.slave bus
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [2:0]            ppp;
      logic [DATA_WIDTH-1:0] data;
   } wb_entry_t;

   wb_entry_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;

   logic                  wen_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [2:0]            ppp_q;
   logic [DATA_WIDTH-1:0] data_q;

   wb_entry_t             alu_entry;
   wb_entry_t             ld_entry;
   wb_entry_t             sel_entry;
   logic                  alu_ready_c;
   logic                  alu_acc;
   logic                  sel;
   logic                  push;
   logic                  pop;

   // Ready depends only on the registered count; gating with reset keeps the
   // producer stalled while reset is held and lets it see ready on the first
   // edge after release.
   assign alu_ready_c = reset && (count != CNT_FULL);
   assign alu_acc     = bus.alu_valid && alu_ready_c;

   assign alu_entry = '{addr: bus.alu_wr_addr, ppp: bus.alu_ppp, data: bus.alu_data};
   assign ld_entry  = '{addr: bus.ld_wr_addr,  ppp: bus.ld_ppp,  data: bus.ld_data};

   // Source select: load, then FIFO head, then ALU bypass when the FIFO is empty.
   always_comb begin
      sel       = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      sel_entry = alu_entry;
      if (bus.ld_valid) begin
         sel       = 1'b1;
         sel_entry = ld_entry;
         push      = alu_acc;
      end else if (count != '0) begin
         sel       = 1'b1;
         pop       = 1'b1;
         sel_entry = mem[rd_ptr];
         push      = alu_acc;
      end else if (alu_acc) begin
         sel       = 1'b1;
         sel_entry = alu_entry;
      end
   end

   // FIFO payload storage; validity is tracked by count, so no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= alu_entry;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Registered RF write port; register 0 is consumed without a write enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wen_q     <= 1'b0;
         wr_addr_q <= '0;
         ppp_q     <= '0;
         data_q    <= '0;
      end else if (sel) begin
         wen_q     <= (sel_entry.addr != '0);
         wr_addr_q <= sel_entry.addr;
         ppp_q     <= sel_entry.ppp;
         data_q    <= sel_entry.data;
      end else begin
         wen_q     <= 1'b0;
      end
   end

   assign bus.alu_ready = alu_ready_c;
   assign bus.wen       = wen_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.PPP_sel   = ppp_q;
   assign bus.data_in   = data_q;

`ifdef WB_FWD_EN
   // Forwarding network sees exactly what the RF is being written with.
   assign bus.fwd_valid = wen_q;
   assign bus.fwd_addr  = wr_addr_q;
   assign bus.fwd_ppp   = ppp_q;
   assign bus.fwd_data  = data_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// ----------------------------------------------------------------------------
// tb_writeback_stage
// Purpose : directed, self-checking bench for writeback_stage with
//           hand-computed expected RF writes.
// ----------------------------------------------------------------------------
module tb_writeback_stage;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   writeback_stage_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

   writeback_stage #(
      .DATA_WIDTH(64),
      .ADDR_WIDTH(5),
      .FIFO_DEPTH(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Compare the whole RF write port against one expected write.
   task automatic check_wr(input string tag, input logic en, input logic [4:0] addr,
                           input logic [2:0] ppp, input logic [63:0] data);
      check({tag, ".wen"},     64'(bus.wen),     64'(en));
      check({tag, ".wr_addr"}, 64'(bus.wr_addr), 64'(addr));
      check({tag, ".PPP_sel"}, 64'(bus.PPP_sel), 64'(ppp));
      check({tag, ".data_in"}, bus.data_in,      data);
`ifdef WB_FWD_EN
      check({tag, ".fwd_valid"}, 64'(bus.fwd_valid), 64'(en));
      check({tag, ".fwd_data"},  bus.fwd_data,       data);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alu_valid   = 1'b0;
      bus.alu_wr_addr = '0;
      bus.alu_ppp     = '0;
      bus.alu_data    = '0;
      bus.ld_valid    = 1'b0;
      bus.ld_wr_addr  = '0;
      bus.ld_ppp      = '0;
      bus.ld_data     = '0;
   endtask

   task automatic drive_alu(input logic [4:0] addr, input logic [2:0] ppp, input logic [63:0] data);
      bus.alu_valid   = 1'b1;
      bus.alu_wr_addr = addr;
      bus.alu_ppp     = ppp;
      bus.alu_data    = data;
   endtask

   task automatic drive_ld(input logic [4:0] addr, input logic [2:0] ppp, input logic [63:0] data);
      bus.ld_valid   = 1'b1;
      bus.ld_wr_addr = addr;
      bus.ld_ppp     = ppp;
      bus.ld_data    = data;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;
      idle();

      // Reset held low for three cycles: everything zero, not ready.
      #1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_wr("rst_hold", 1'b0, 5'd0, 3'd0, 64'h0);
         check("rst_hold.alu_ready", 64'(bus.alu_ready), 64'h0);
      end
      reset = 1'b1;
      #1;
      check("rst_rel.alu_ready", 64'(bus.alu_ready), 64'h1);
      tick();
      check_wr("rst_idle", 1'b0, 5'd0, 3'd0, 64'h0);

      // Single ALU result with latency 1, then hold on idle.
      drive_alu(5'd3, 3'b000, 64'h0123_4567_89AB_CDEF);
      tick();
      idle();
      check_wr("alu_single", 1'b1, 5'd3, 3'b000, 64'h0123_4567_89AB_CDEF);
      tick();
      check_wr("alu_hold", 1'b0, 5'd3, 3'b000, 64'h0123_4567_89AB_CDEF);

      // PPP passthrough.
      drive_alu(5'd9, 3'b101, 64'hDEAD_BEEF_0000_0009);
      tick();
      idle();
      check_wr("alu_ppp", 1'b1, 5'd9, 3'b101, 64'hDEAD_BEEF_0000_0009);

      // Four loads 5..8 with ALU 10,11,12 streaming; FIFO fills, then drains.
      drive_ld(5'd5, 3'd0, 64'h50);
      drive_alu(5'd10, 3'd1, 64'hA0);
      tick();
      check_wr("ld5", 1'b1, 5'd5, 3'd0, 64'h50);
      check("ld5.alu_ready", 64'(bus.alu_ready), 64'h1);
      drive_ld(5'd6, 3'd0, 64'h60);
      drive_alu(5'd11, 3'd2, 64'hB0);
      tick();
      check_wr("ld6", 1'b1, 5'd6, 3'd0, 64'h60);
      check("ld6.alu_ready", 64'(bus.alu_ready), 64'h0);
      drive_ld(5'd7, 3'd0, 64'h70);
      drive_alu(5'd12, 3'd3, 64'hC0);
      tick();
      check_wr("ld7", 1'b1, 5'd7, 3'd0, 64'h70);
      check("ld7.alu_ready", 64'(bus.alu_ready), 64'h0);
      drive_ld(5'd8, 3'd0, 64'h80);
      tick();
      check_wr("ld8", 1'b1, 5'd8, 3'd0, 64'h80);
      check("ld8.alu_ready", 64'(bus.alu_ready), 64'h0);
      bus.ld_valid = 1'b0;
      tick();
      check_wr("drain10", 1'b1, 5'd10, 3'd1, 64'hA0);
      check("drain10.alu_ready", 64'(bus.alu_ready), 64'h1);
      tick();
      idle();
      check_wr("drain11", 1'b1, 5'd11, 3'd2, 64'hB0);
      tick();
      check_wr("drain12", 1'b1, 5'd12, 3'd3, 64'hC0);
      tick();
      check_wr("drain_done", 1'b0, 5'd12, 3'd3, 64'hC0);

      // Same-register collision: load first, ALU value lands last.
      drive_ld(5'd7, 3'd2, 64'h1);
      drive_alu(5'd7, 3'd4, 64'h2);
      tick();
      idle();
      check_wr("coll_ld", 1'b1, 5'd7, 3'd2, 64'h1);
      tick();
      check_wr("coll_alu", 1'b1, 5'd7, 3'd4, 64'h2);
      tick();
      check_wr("coll_idle", 1'b0, 5'd7, 3'd4, 64'h2);

      // Register 0: consumed without write enable, FIFO stays empty.
      drive_alu(5'd0, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      check_wr("r0", 1'b0, 5'd0, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF);
      check("r0.alu_ready", 64'(bus.alu_ready), 64'h1);
      drive_alu(5'd4, 3'd1, 64'h44);
      tick();
      idle();
      check_wr("r0_next", 1'b1, 5'd4, 3'd1, 64'h44);
      tick();
      check_wr("r0_idle", 1'b0, 5'd4, 3'd1, 64'h44);

      // Fill FIFO, pulse reset: buffered data must never reach the RF.
      drive_ld(5'd1, 3'd0, 64'h11);
      drive_alu(5'd20, 3'd5, 64'hD0);
      tick();
      check_wr("fill_ld1", 1'b1, 5'd1, 3'd0, 64'h11);
      drive_ld(5'd2, 3'd0, 64'h22);
      drive_alu(5'd21, 3'd6, 64'hD1);
      tick();
      check_wr("fill_ld2", 1'b1, 5'd2, 3'd0, 64'h22);
      check("fill.alu_ready", 64'(bus.alu_ready), 64'h0);
      idle();
      reset = 1'b0;
      #1;
      check_wr("midrst", 1'b0, 5'd0, 3'd0, 64'h0);
      check("midrst.alu_ready", 64'(bus.alu_ready), 64'h0);
      tick();
      reset = 1'b1;
      #1;
      check("midrst_rel.alu_ready", 64'(bus.alu_ready), 64'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_wr("post_rst", 1'b0, 5'd0, 3'd0, 64'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 64, RF write data width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 5, RF register address width.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 2, ALU-result buffer entries (power of two, at least 2).
REQ-004 The module SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-005 The module SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 The module SHALL have ports alu_valid in 1, alu_wr_addr in ADDR_WIDTH, alu_ppp in 3, alu_data in DATA_WIDTH: in-order ALU result.
REQ-007 The module SHALL have port alu_ready  out  1  ALU result accepted when alu_valid and alu_ready are both high.
REQ-008 The module SHALL have ports ld_valid in 1, ld_wr_addr in ADDR_WIDTH, ld_ppp in 3, ld_data in DATA_WIDTH: load return from the network interface, no backpressure.
REQ-009 The module SHALL have ports wen out 1, wr_addr out ADDR_WIDTH, PPP_sel out 3, data_in out DATA_WIDTH: registered RF write port.

Function
REQ-010 The block SHALL hold a FIFO_DEPTH-entry circular FIFO of ALU results {addr, ppp, data}, with read and write pointers wrapping modulo FIFO_DEPTH and an occupancy count 0..FIFO_DEPTH.
REQ-011 alu_ready SHALL equal (count != FIFO_DEPTH), derived from registered state only, with no combinational path from any valid input.
REQ-012 Per cycle, write-port source priority SHALL be: ld_valid, then FIFO head if count > 0, then the direct ALU input if alu_valid and count == 0.
REQ-013 The selected source SHALL appear on wen/wr_addr/PPP_sel/data_in exactly one cycle after the edge on which it is captured (latency 1).
REQ-014 An accepted ALU result not selected in the same cycle SHALL be pushed to the FIFO; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-015 ALU results SHALL reach the RF in acceptance order; loads MAY interleave between them.
REQ-016 An entry with wr_addr == 0 SHALL be consumed normally, with wen driven 0 for that cycle and wr_addr/PPP_sel/data_in still driven.
REQ-017 When ld_valid and an accepted ALU result target the same register in the same cycle, the load SHALL be written first and the ALU value SHALL be written later, so the ALU value is final.
REQ-018 In a cycle with no source selected, wen SHALL be 0 and wr_addr/PPP_sel/data_in SHALL hold their previous values.
REQ-019 PPP_sel SHALL be passed through unmodified from the selected source's ppp field.
REQ-020 With continuous ld_valid, the FIFO SHALL fill and alu_ready SHALL drop, with no ALU result lost or duplicated.

Reset
REQ-021 While reset is low, wen, wr_addr, PPP_sel, data_in, count and both pointers SHALL be 0 and alu_ready SHALL be 0.
REQ-022 The first rising clk edge after reset goes high SHALL see alu_ready = 1.
REQ-023 Reset asserted mid-operation SHALL immediately discard all FIFO contents, with no RF write of buffered data afterwards.

Configuration
REQ-024 With macro WB_FWD_EN defined, the block SHALL add outputs fwd_valid (1), fwd_addr (ADDR_WIDTH), fwd_ppp (3), fwd_data (DATA_WIDTH) for the operand-forwarding network.
REQ-025 Under WB_FWD_EN, these outputs SHALL be combinational copies of the value being presented to the RF this cycle, with fwd_valid equal to wen.
REQ-026 Without WB_FWD_EN, these ports SHALL NOT exist and behaviour SHALL be otherwise identical.

Verification
REQ-027 Scenario: reset low for 3 cycles, then released -> all outputs 0 during reset; alu_ready = 1 on the first edge after release.
REQ-028 Scenario: single ALU result addr 3, ppp 3'b000, data 64'h0123_4567_89AB_CDEF, idle otherwise -> next cycle wen = 1, wr_addr = 3, data_in = 64'h0123_4567_89AB_CDEF.
REQ-029 Scenario: ld_valid held 4 cycles (addrs 5..8) while ALU issues addrs 10, 11, 12 back-to-back -> loads written 5..8; alu_ready = 0 after two ALU pushes; then ALU results written 10, 11, 12 in order, none lost.
REQ-030 Scenario: same cycle, ld addr 7 = 64'h1 and ALU addr 7 = 64'h2 -> RF writes 64'h1 then 64'h2 on consecutive cycles.
REQ-031 Scenario: ALU result addr 0, data 64'hFFFF_FFFF_FFFF_FFFF -> wen = 0 that cycle; FIFO count unchanged afterwards.
REQ-032 Scenario: FIFO full (2 entries), reset pulsed low 1 cycle -> no subsequent RF write of the buffered data; count = 0.
